// File: rtl/elevator_pkg.sv
// Shared types for the elevator controller: FSM state encoding and its width.
package elevator_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

endpackage

// File: rtl/elevator_ctrl_tick_gen.sv
// Free-running movement-tick generator: one registered pulse every TICK_DIV clock cycles.
module tick_gen #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 2);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // tick is registered one count early so it is high exactly while cnt == LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == PRE_LAST);
    end
  end

endmodule

// File: rtl/elevator_ctrl.sv
// N-floor collective elevator controller: latched requests, sweep scheduling, timed door.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS),
  parameter int TICK_DIV   = 10_000_000,
  parameter int DOOR_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [FLOOR_W-1:0]    floor,
  output logic [NUM_FLOORS-1:0] floor_onehot,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  tick
);

  localparam int DOOR_W = $clog2(DOOR_TICKS + 1);
  localparam logic [DOOR_W-1:0]  DOOR_LOAD  = DOOR_W'(DOOR_TICKS);
  localparam logic [FLOOR_W:0]   FLOORS_EXT = (FLOOR_W + 1)'(NUM_FLOORS);

  state_t state, state_next;

  logic [FLOOR_W-1:0]    floor_next, step_floor;
  logic                  dir_next;
  logic [DOOR_W-1:0]     door_cnt, door_cnt_next;
  logic [NUM_FLOORS-1:0] pending_next, set_mask, clear_mask;
  logic [NUM_FLOORS-1:0] above_mask, below_mask;
  logic [NUM_FLOORS-1:0] onehot_next;
  logic                  ahead, behind;
  logic                  req_in_range, door_reload;
  logic                  moving_next, door_open_next;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Thermometer masks split pending into floors strictly above and below the car.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so no
    // latch can be inferred.
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_mask[i] = (FLOOR_W'(i) > floor);
      below_mask[i] = (FLOOR_W'(i) < floor);
    end
  end

  assign ahead      = dir_up ? |(pending & above_mask) : |(pending & below_mask);
  assign behind     = dir_up ? |(pending & below_mask) : |(pending & above_mask);
  assign step_floor = dir_up ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);

  // A current-floor request while the door is open only extends the door time.
  assign req_in_range = ({1'b0, req_floor} < FLOORS_EXT);
  assign door_reload  = req_valid && req_in_range && (state == DOOR) && (req_floor == floor);

  always_comb begin
    set_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      set_mask[i] = req_valid && req_in_range && !door_reload && (req_floor == FLOOR_W'(i));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath decisions; the FSM only advances on tick cycles.
  always_comb begin
    state_next    = state;
    floor_next    = floor;
    dir_next      = dir_up;
    door_cnt_next = door_cnt;
    clear_mask    = '0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (pending[floor]) begin
            clear_mask[floor] = 1'b1;
            door_cnt_next     = DOOR_LOAD;
            state_next        = DOOR;
          end else if (ahead) begin
            state_next = MOVE;
          end else if (behind) begin
            dir_next   = ~dir_up;
            state_next = MOVE;
          end
        end
        MOVE: begin
          floor_next = step_floor;
          if (pending[step_floor]) begin
            clear_mask[step_floor] = 1'b1;
            door_cnt_next          = DOOR_LOAD;
            state_next             = DOOR;
          end
        end
        DOOR: begin
          door_cnt_next = door_cnt - DOOR_W'(1);
          if (door_cnt == DOOR_W'(1)) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
    if (door_reload) begin
      door_cnt_next = DOOR_LOAD;
      state_next    = DOOR;
    end
  end

  // Clear beats a same-cycle set: a request for the floor being served counts as served.
  assign pending_next = (pending | set_mask) & ~clear_mask;

  // Output decode from the next state so every status output leaves a flop.
  always_comb begin
    moving_next    = (state_next == MOVE);
    door_open_next = (state_next == DOOR);
    onehot_next    = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      onehot_next[i] = (floor_next == FLOOR_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      floor        <= '0;
      floor_onehot <= NUM_FLOORS'(1);
      pending      <= '0;
      dir_up       <= 1'b1;
      door_cnt     <= '0;
      moving       <= 1'b0;
      door_open    <= 1'b0;
    end else begin
      floor        <= floor_next;
      floor_onehot <= onehot_next;
      pending      <= pending_next;
      dir_up       <= dir_next;
      door_cnt     <= door_cnt_next;
      moving       <= moving_next;
      door_open    <= door_open_next;
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl: travel, collective stops, reversal, door reload, reset.
module tb_elevator_ctrl;

  logic       clk, rst_n;
  logic       req_valid;
  logic [2:0] req_floor, floor;
  logic [7:0] floor_onehot, pending;
  logic       dir_up, moving, door_open, tick;

  logic       req_valid6;
  logic [2:0] req_floor6, floor6;
  logic [5:0] floor_onehot6, pending6;
  logic       dir_up6, moving6, door_open6, tick6;

  int checks = 0;
  int errors = 0;

  elevator_ctrl #(.NUM_FLOORS(8), .TICK_DIV(4), .DOOR_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_floor(req_floor),
    .floor(floor), .floor_onehot(floor_onehot), .pending(pending), .dir_up(dir_up),
    .moving(moving), .door_open(door_open), .tick(tick)
  );

  elevator_ctrl #(.NUM_FLOORS(6), .TICK_DIV(4), .DOOR_TICKS(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid6), .req_floor(req_floor6),
    .floor(floor6), .floor_onehot(floor_onehot6), .pending(pending6), .dir_up(dir_up6),
    .moving(moving6), .door_open(door_open6), .tick(tick6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs until the FSM has consumed one tick edge; bounded by two tick periods.
  task automatic wait_tick_edge();
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (tick === 1'b1) seen = 1'b1;
      step();
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL tick_timeout: no tick within 8 cycles (floor=%0d)", floor);
    end
  endtask

  task automatic request(input logic [2:0] f);
    req_valid = 1'b1;
    req_floor = f;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({floor, floor_onehot, pending, dir_up, moving, door_open, tick} !==
        {3'd0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: floor=%0d onehot=%h pending=%h dir=%b mov=%b door=%b tick=%b",
               floor, floor_onehot, pending, dir_up, moving, door_open, tick);
    end
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++;
      if (tick !== (c == 3 || c == 7)) begin
        errors++;
        $display("FAIL tick_cycle_%0d: got %b expected %b", c, tick, (c == 3 || c == 7));
      end
    end
    checks++;
    if ({moving, door_open, pending} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL idle_stays: mov=%b door=%b pending=%h expected 0/0/00", moving, door_open, pending);
    end
  endtask

  task automatic test_request_3();
    do_reset();
    request(3'd3);
    checks++;
    if (pending !== 8'h08) begin
      errors++; $display("FAIL req3_pending: got %h expected 08", pending);
    end
    wait_tick_edge();
    checks++;
    if ({moving, floor} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL req3_depart: mov=%b floor=%0d expected 1/0", moving, floor);
    end
    for (int f = 1; f <= 3; f++) begin
      wait_tick_edge();
      checks++;
      if (floor !== 3'(f) || floor_onehot !== (8'h01 << f)) begin
        errors++;
        $display("FAIL req3_floor: floor=%0d onehot=%h expected %0d", floor, floor_onehot, f);
      end
    end
    checks++;
    if ({door_open, moving, pending} !== {1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL req3_arrive: door=%b mov=%b pending=%h expected 1/0/00", door_open, moving, pending);
    end
    wait_tick_edge();
    checks++;
    if (door_open !== 1'b1) begin
      errors++; $display("FAIL req3_door_hold: door=%b expected 1", door_open);
    end
    wait_tick_edge();
    checks++;
    if ({door_open, moving} !== 2'b00) begin
      errors++; $display("FAIL req3_idle: door=%b mov=%b expected 0/0", door_open, moving);
    end
  endtask

  task automatic test_collective();
    do_reset();
    request(3'd5);
    wait_tick_edge();
    wait_tick_edge();
    checks++;
    if (floor !== 3'd1) begin
      errors++; $display("FAIL coll_at1: floor=%0d expected 1", floor);
    end
    request(3'd2);
    wait_tick_edge();
    checks++;
    if ({floor, door_open, dir_up, pending} !== {3'd2, 1'b1, 1'b1, 8'h20}) begin
      errors++;
      $display("FAIL coll_stop2: floor=%0d door=%b dir=%b pending=%h expected 2/1/1/20",
               floor, door_open, dir_up, pending);
    end
    wait_tick_edge();
    wait_tick_edge();
    wait_tick_edge();
    checks++;
    if ({moving, floor, dir_up} !== {1'b1, 3'd2, 1'b1}) begin
      errors++; $display("FAIL coll_resume: mov=%b floor=%0d dir=%b expected 1/2/1", moving, floor, dir_up);
    end
    for (int f = 3; f <= 5; f++) begin
      wait_tick_edge();
      checks++;
      if (floor !== 3'(f) || dir_up !== 1'b1) begin
        errors++; $display("FAIL coll_floor: floor=%0d dir=%b expected %0d/1", floor, dir_up, f);
      end
    end
    checks++;
    if ({door_open, pending} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL coll_stop5: door=%b pending=%h expected 1/00", door_open, pending);
    end
  endtask

  task automatic test_reversal();
    do_reset();
    request(3'd6);
    for (int i = 0; i < 5; i++) wait_tick_edge();
    checks++;
    if (floor !== 3'd4) begin
      errors++; $display("FAIL rev_at4: floor=%0d expected 4", floor);
    end
    request(3'd1);
    wait_tick_edge();
    wait_tick_edge();
    checks++;
    if ({floor, door_open, dir_up, pending} !== {3'd6, 1'b1, 1'b1, 8'h02}) begin
      errors++;
      $display("FAIL rev_serve6: floor=%0d door=%b dir=%b pending=%h expected 6/1/1/02",
               floor, door_open, dir_up, pending);
    end
    wait_tick_edge();
    wait_tick_edge();
    wait_tick_edge();
    checks++;
    if ({moving, dir_up, floor} !== {1'b1, 1'b0, 3'd6}) begin
      errors++; $display("FAIL rev_turn: mov=%b dir=%b floor=%0d expected 1/0/6", moving, dir_up, floor);
    end
    for (int f = 5; f >= 1; f--) begin
      wait_tick_edge();
      checks++;
      if (floor !== 3'(f)) begin
        errors++; $display("FAIL rev_floor: floor=%0d expected %0d", floor, f);
      end
    end
    checks++;
    if ({door_open, dir_up, pending} !== {1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL rev_stop1: door=%b dir=%b pending=%h expected 1/0/00", door_open, dir_up, pending);
    end
  endtask

  task automatic test_boundaries();
    do_reset();
    req_valid6 = 1'b1; req_floor6 = 3'd7;
    step();
    req_valid6 = 1'b0;
    checks++;
    if (pending6 !== 6'h00) begin
      errors++; $display("FAIL range_drop7: pending=%h expected 00", pending6);
    end
    req_valid6 = 1'b1; req_floor6 = 3'd5;
    step();
    req_valid6 = 1'b0;
    checks++;
    if (pending6 !== 6'h20) begin
      errors++; $display("FAIL range_top5: pending=%h expected 20", pending6);
    end

    request(3'd0);
    wait_tick_edge();
    checks++;
    if ({door_open, pending} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL door_here: door=%b pending=%h expected 1/00", door_open, pending);
    end
    wait_tick_edge();
    request(3'd0);
    checks++;
    if ({door_open, pending} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL door_reload_req: door=%b pending=%h expected 1/00", door_open, pending);
    end
    wait_tick_edge();
    checks++;
    if (door_open !== 1'b1) begin
      errors++; $display("FAIL door_extended: door=%b expected 1", door_open);
    end
    wait_tick_edge();
    checks++;
    if ({door_open, pending} !== {1'b0, 8'h00}) begin
      errors++; $display("FAIL door_closed: door=%b pending=%h expected 0/00", door_open, pending);
    end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    request(3'd5);
    for (int i = 0; i < 3; i++) wait_tick_edge();
    checks++;
    if ({moving, floor} !== {1'b1, 3'd2}) begin
      errors++; $display("FAIL abort_setup: mov=%b floor=%0d expected 1/2", moving, floor);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({floor, floor_onehot, pending, dir_up, moving, door_open, tick} !==
        {3'd0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_async: floor=%0d onehot=%h pending=%h dir=%b mov=%b door=%b tick=%b",
               floor, floor_onehot, pending, dir_up, moving, door_open, tick);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    request(3'd2);
    checks++;
    if (pending !== 8'h04) begin
      errors++; $display("FAIL resume_pending: got %h expected 04", pending);
    end
    for (int i = 0; i < 3; i++) wait_tick_edge();
    checks++;
    if ({floor, door_open, pending} !== {3'd2, 1'b1, 8'h00}) begin
      errors++; $display("FAIL resume_arrive: floor=%0d door=%b pending=%h expected 2/1/00",
                         floor, door_open, pending);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_floor  = 3'd0;
    req_valid6 = 1'b0;
    req_floor6 = 3'd0;
    test_reset();
    test_request_3();
    test_collective();
    test_reversal();
    test_boundaries();
    test_reset_mid_move();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Parametrised N-floor elevator controller with latched floor requests, collective (sweep) scheduling, and a timed door state. It replaces the fixed 4-floor, single-target controller: any number of outstanding requests, stops at every requested floor on the way, reverses only when nothing is pending ahead. It sits behind the chip's top-level wrapper, which maps pins to `req_valid`/`req_floor` and drives status outputs from `floor`, `door_open` and `dir_up`.

## Interface
- `NUM_FLOORS`, default 8: floors served (≥2).
- `FLOOR_W`, default `$clog2(NUM_FLOORS)`: floor index width.
- `TICK_DIV`, default 10_000_000: clk cycles per movement tick (≥2).
- `DOOR_TICKS`, default 3: ticks the door stays open (≥1).

- `clk`  in  1  the single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  one-cycle request strobe.
- `req_floor`  in  FLOOR_W  requested floor, sampled when `req_valid`=1.
- `floor`  out  FLOOR_W  current floor, binary.
- `floor_onehot`  out  NUM_FLOORS  current floor, one-hot.
- `pending`  out  NUM_FLOORS  latched outstanding requests.
- `dir_up`  out  1  sweep direction (1 = up).
- `moving`  out  1  high in MOVE.
- `door_open`  out  1  high in DOOR.
- `tick`  out  1  one-cycle movement-tick pulse.

## Operation
- Tick generator: counter 0..TICK_DIV-1; `tick`=1 for the cycle the counter equals TICK_DIV-1, then wraps to 0.
- Request latch: `req_valid` with `req_floor` < NUM_FLOORS sets `pending[req_floor]`. Out-of-range requests are silently dropped. Exception: in DOOR, a request for the current floor does not set the bit; it reloads the door counter to DOOR_TICKS.
- "Ahead" = any pending bit strictly above `floor` if `dir_up`, strictly below otherwise. "Behind" = the opposite side.
- FSM states: IDLE, MOVE, DOOR. The FSM advances only on cycles with `tick`=1.
  - IDLE:
    - If `pending[floor]`: clear it, enter DOOR, load door counter = DOOR_TICKS.
    - Else if ahead: enter MOVE.
    - Else if behind: toggle `dir_up`, enter MOVE.
    - Else stay in IDLE.
  - MOVE: step `floor` ±1 per `dir_up`.
    - If `pending[new floor]`: clear it, enter DOOR with counter loaded.
    - Else stay in MOVE.
    - Floor never leaves 0..NUM_FLOORS-1, because MOVE is entered only with a target ahead and pending bits are cleared only on arrival.
  - DOOR: decrement the counter. When it goes 1→0, enter IDLE.
- Same-cycle set and clear of one pending bit: the clear wins only for the served floor on DOOR entry; the request is treated as served.

## Timing
- Reset (async assert, sync-release use): `floor`=0, `floor_onehot`=1, `pending`=0, `dir_up`=1, `moving`=0, `door_open`=0, `tick`=0, state=IDLE, both counters 0.
- All outputs are registered.
- `pending` reflects a request the cycle after `req_valid`.
- Decision latency: IDLE leaves on the first tick after the bit is set. The first floor step happens one tick later, so travel costs 1 tick per floor plus 1 tick for departure.
- `door_open` is high for exactly DOOR_TICKS ticks per stop, extended by each current-floor reload.
- Reset mid-MOVE or mid-DOOR aborts immediately. Pending requests are lost.

## Structure
- Package `elevator_pkg`: state enum (IDLE, MOVE, DOOR) and the state width constant.
- Sub-module `tick_gen`: parameter TICK_DIV; ports `clk`, `rst_n`, `tick`.
- Ahead/behind detection is combinational masking of `pending` against a thermometer mask of `floor`.

## Test plan
Bench parameters: NUM_FLOORS=8, TICK_DIV=4, DOOR_TICKS=2, unless noted.
- Reset, then idle: all outputs at reset values; `tick` pulses every 4 cycles, first pulse at cycle 3.
- Request 3 from floor 0:
  - `pending`=0x08 next cycle.
  - MOVE on the next tick; `floor` = 1, 2, 3 on the following ticks.
  - At 3: `door_open`=1, `pending`=0.
  - IDLE after 2 ticks.
- Collective stop: heading up from 0 to 5, request 2 while `floor`=1 → door opens at 2, then at 5. `dir_up` stays 1 throughout.
- Reversal: at 4 going up to 6, request 1 → serves 6, IDLE, `dir_up`=0, descends and stops at 1.
- Boundaries: with NUM_FLOORS=6, `req_floor`=7 is ignored (`pending` unchanged). A current-floor request during DOOR keeps `door_open` for 2 ticks after that request, and `pending` stays 0.
- Drop `rst_n` mid-MOVE at floor 2: outputs take reset values within the same cycle with no clock edge. Operation resumes normally after release.
